// File: rtl/ifft_pkg.sv
// Shared types and fixed-point helpers for the streaming inverse FFT.
// Samples are packed {im, re}, each signed Q1.7.
package ifft_pkg;

    localparam int FRAC_W = 7;

    typedef logic signed [7:0] sample_t;
    typedef logic signed [9:0] acc_t;

    localparam sample_t TW_C45 = 8'sd90;

    typedef struct packed {
        sample_t im;
        sample_t re;
    } complex_t;

    typedef struct packed {
        acc_t im;
        acc_t re;
    } wide_c_t;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    function automatic int bitrev(input int idx, input int log2n);
        int r;
        r = 0;
        for (int b = 0; b < 3; b++) begin
            if (b < log2n && idx[b]) r[log2n - 1 - b] = 1'b1;
        end
        return r;
    endfunction

    function automatic sample_t sat8(input logic signed [10:0] v);
        if (v > 11'sd127)
            return 8'sh7f;
        else if (v < -11'sd128)
            return 8'sh80;
        else
            return v[7:0];
    endfunction

    function automatic acc_t ext8(input sample_t x);
        return {{2{x[7]}}, x};
    endfunction

    function automatic acc_t prod_q(input sample_t x, input sample_t c);
        logic signed [15:0] p;
        p = x * c;
        return acc_t'(p >>> FRAC_W);
    endfunction

    // Twiddle exp(+j*2*pi*tw_idx/len), normalised to eighth-turn steps.
    function automatic wide_c_t cmul_tw(input complex_t b, input logic [2:0] tw_idx,
                                        input logic [3:0] len);
        logic [1:0] k8;
        sample_t    c;
        sample_t    s;
        wide_c_t    t;
        case (len)
            4'd8:    k8 = tw_idx[1:0];
            4'd4:    k8 = {tw_idx[0], 1'b0};
            default: k8 = 2'd0;
        endcase
        s = TW_C45;
        c = (k8 == 2'd3) ? -TW_C45 : TW_C45;
        case (k8)
            2'd0: begin
                t.re = ext8(b.re);
                t.im = ext8(b.im);
            end
            2'd2: begin
                t.re = (b.im == 8'sh80) ? 10'sd127 : -ext8(b.im);
                t.im = ext8(b.re);
            end
            default: begin
                t.re = prod_q(b.re, c) - prod_q(b.im, s);
                t.im = prod_q(b.re, s) + prod_q(b.im, c);
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Radix-2 DIT butterfly with inverse twiddle and per-stage 1/2 scaling.
module ifft_butterfly import ifft_pkg::*; (
    input  complex_t   a,
    input  complex_t   b,
    input  logic [2:0] tw_idx,
    input  logic [3:0] tw_len,
    output complex_t   a_new,
    output complex_t   b_new
);

    wide_c_t            t;
    logic signed [10:0] sum_re;
    logic signed [10:0] sum_im;
    logic signed [10:0] dif_re;
    logic signed [10:0] dif_im;

    always_comb begin
        t      = cmul_tw(b, tw_idx, tw_len);
        sum_re = {{3{a.re[7]}}, a.re} + {t.re[9], t.re};
        sum_im = {{3{a.im[7]}}, a.im} + {t.im[9], t.im};
        dif_re = {{3{a.re[7]}}, a.re} - {t.re[9], t.re};
        dif_im = {{3{a.im[7]}}, a.im} - {t.im[9], t.im};
        a_new.re = sat8(sum_re >>> 1);
        a_new.im = sat8(sum_im >>> 1);
        b_new.re = sat8(dif_re >>> 1);
        b_new.im = sat8(dif_im >>> 1);
    end

endmodule

// File: rtl/ifft_np.sv
// Streaming N-point inverse FFT: load in bit-reversed order, one DIT stage
// per clock, then unload time samples in natural order.
module ifft_np import ifft_pkg::*; #(
    parameter int N            = 4,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SAMPLE_WIDTH-1:0] in_sample,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SAMPLE_WIDTH-1:0] out_sample,
    output logic                    out_last,
    output logic                    busy
);

    localparam int LOG2N = (N == 8) ? 3 : 2;
    localparam int HALF  = N / 2;

    if ((N != 4 && N != 8) || SAMPLE_WIDTH != 16) begin : g_bad_param
        $error("ifft_np: N must be 4 or 8 and SAMPLE_WIDTH must be 16");
    end

    state_t           state;
    logic [LOG2N-1:0] cnt;
    logic [1:0]       stage;
    complex_t         mem [N];
    logic [LOG2N-1:0] load_idx;

    complex_t         bf_a     [HALF];
    complex_t         bf_b     [HALF];
    complex_t         bf_a_new [HALF];
    complex_t         bf_b_new [HALF];
    logic [LOG2N-1:0] top_idx  [HALF];
    logic [LOG2N-1:0] bot_idx  [HALF];
    logic [2:0]       tw_idx   [HALF];
    logic [3:0]       tw_len;

    assign load_idx = LOG2N'(bitrev(int'(cnt), LOG2N));

    // Butterfly i of stage s pairs (top, top + 2^s) inside groups of 2^(s+1).
    always_comb begin : route
        int half;
        int pos;
        int top;
        half   = 1 << stage;
        tw_len = 4'(2 << stage);
        for (int i = 0; i < HALF; i++) begin
            pos        = i & (half - 1);
            top        = ((i >> stage) << (stage + 1)) | pos;
            top_idx[i] = LOG2N'(top);
            bot_idx[i] = LOG2N'(top + half);
            tw_idx[i]  = 3'(pos);
            bf_a[i]    = mem[top_idx[i]];
            bf_b[i]    = mem[bot_idx[i]];
        end
    end

    for (genvar g = 0; g < HALF; g++) begin : g_bf
        ifft_butterfly u_bf (
            .a      (bf_a[g]),
            .b      (bf_b[g]),
            .tw_idx (tw_idx[g]),
            .tw_len (tw_len),
            .a_new  (bf_a_new[g]),
            .b_new  (bf_b_new[g])
        );
    end

    // A transfer happens on a rising edge where valid && ready; the source holds
    // its payload stable while valid is high and ready is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            cnt        <= '0;
            stage      <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            out_sample <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        mem[load_idx] <= in_sample;
                        if (cnt == LOG2N'(N - 1)) begin
                            cnt      <= '0;
                            stage    <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= ST_COMPUTE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    // The extra cycle after the last stage registers x[0].
                    if (stage == 2'(LOG2N)) begin
                        out_valid  <= 1'b1;
                        out_sample <= mem[0];
                        out_last   <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_UNLOAD;
                    end else begin
                        for (int i = 0; i < HALF; i++) begin
                            mem[top_idx[i]] <= bf_a_new[i];
                            mem[bot_idx[i]] <= bf_b_new[i];
                        end
                        stage <= stage + 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            cnt       <= '0;
                            state     <= ST_LOAD;
                        end else begin
                            cnt        <= cnt + 1'b1;
                            out_sample <= mem[cnt + 1'b1];
                            out_last   <= (cnt + 1'b1 == LOG2N'(N - 1));
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft_np.sv
// Bench for ifft_np: N=4 and N=8 instances checked against a floating-angle
// fixed-point IFFT model, plus directed latency, backpressure and abort cases.
module tb_ifft_np;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv4 = 1'b0, ordy4 = 1'b1;
    logic        ir4, ov4, ol4, bz4;
    logic [15:0] is4 = '0, os4;
    logic        iv8 = 1'b0, ordy8 = 1'b1;
    logic        ir8, ov8, ol8, bz8;
    logic [15:0] is8 = '0, os8;

    int tests = 0;
    int fails = 0;
    int or_mode = 0;

    logic [16:0] exp4_q[$];
    logic [16:0] exp8_q[$];
    logic        hold4 = 1'b0, hold8 = 1'b0;
    logic [16:0] held4, held8;

    ifft_np #(.N(4), .SAMPLE_WIDTH(16)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_sample(is4),
        .out_valid(ov4), .out_ready(ordy4), .out_sample(os4), .out_last(ol4), .busy(bz4)
    );

    ifft_np #(.N(8), .SAMPLE_WIDTH(16)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_sample(is8),
        .out_valid(ov8), .out_ready(ordy8), .out_sample(os8), .out_last(ol8), .busy(bz8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    // Direct DIT IFFT over integers; twiddles derived from the angle itself.
    function automatic void ifft_model(input int n, input logic [15:0] xin[8],
                                       output logic [15:0] yout[8]);
        int  re[8];
        int  im[8];
        int  lg, rev, h, ar, ai, br, bi, tr, ti, c, s;
        real ang;
        lg = (n == 8) ? 3 : 2;
        for (int k = 0; k < 8; k++) begin
            re[k] = 0; im[k] = 0; yout[k] = '0;
        end
        for (int k = 0; k < n; k++) begin
            rev = 0;
            for (int b = 0; b < lg; b++)
                if (((k >> b) & 1) != 0) rev = rev | (1 << (lg - 1 - b));
            re[rev] = int'($signed(xin[k][7:0]));
            im[rev] = int'($signed(xin[k][15:8]));
        end
        for (int len = 2; len <= n; len = len * 2) begin
            h = len / 2;
            for (int base = 0; base < n; base += len) begin
                for (int m = 0; m < h; m++) begin
                    ar = re[base + m];     ai = im[base + m];
                    br = re[base + m + h]; bi = im[base + m + h];
                    if (m == 0) begin
                        tr = br; ti = bi;
                    end else if (4 * m == len) begin
                        tr = (bi == -128) ? 127 : -bi;
                        ti = br;
                    end else begin
                        ang = 2.0 * 3.141592653589793 * m / len;
                        c = $rtoi($cos(ang) * 128.0);
                        s = $rtoi($sin(ang) * 128.0);
                        tr = ((br * c) >>> 7) - ((bi * s) >>> 7);
                        ti = ((br * s) >>> 7) + ((bi * c) >>> 7);
                    end
                    re[base + m]     = sat((ar + tr) >>> 1);
                    im[base + m]     = sat((ai + ti) >>> 1);
                    re[base + m + h] = sat((ar - tr) >>> 1);
                    im[base + m + h] = sat((ai - ti) >>> 1);
                end
            end
        end
        for (int k = 0; k < n; k++) yout[k] = {im[k][7:0], re[k][7:0]};
    endfunction

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0: begin ordy4 = 1'b1; ordy8 = 1'b1; end
            1: begin
                ordy4 = ($urandom_range(0, 3) != 0);
                ordy8 = ($urandom_range(0, 3) != 0);
            end
            default: begin ordy4 = 1'b0; ordy8 = 1'b0; end
        endcase
    end

    // Scoreboard: every transfer pops the expected {last, sample}.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            exp4_q.delete();
            exp8_q.delete();
            hold4 = 1'b0;
            hold8 = 1'b0;
        end else begin
            check("dut4_ready_vs_busy", ir4, !bz4);
            check("dut8_ready_vs_busy", ir8, !bz8);
            if (hold4) check("dut4_hold", {ov4, ol4, os4}, {1'b1, held4});
            if (hold8) check("dut8_hold", {ov8, ol8, os8}, {1'b1, held8});
            if (ov4 && ordy4) begin
                if (exp4_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut4_extra_output: got %h, expected no output", {ol4, os4});
                end else begin
                    e = exp4_q.pop_front();
                    check("dut4_sample", {ol4, os4}, e);
                end
            end
            if (ov8 && ordy8) begin
                if (exp8_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut8_extra_output: got %h, expected no output", {ol8, os8});
                end else begin
                    e = exp8_q.pop_front();
                    check("dut8_sample", {ol8, os8}, e);
                end
            end
            hold4 = ov4 && !ordy4; held4 = {ol4, os4};
            hold8 = ov8 && !ordy8; held8 = {ol8, os8};
        end
    end

    task automatic do_reset();
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input bit sel8, input logic [15:0] x[8], input bit gaps);
        int          n;
        int          cnt;
        logic [15:0] y[8];
        n = sel8 ? 8 : 4;
        ifft_model(n, x, y);
        for (int k = 0; k < n; k++) begin
            if (sel8) exp8_q.push_back({k == n - 1, y[k]});
            else      exp4_q.push_back({k == n - 1, y[k]});
        end
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            if (sel8) begin iv8 = 1'b1; is8 = x[k]; end
            else      begin iv4 = 1'b1; is4 = x[k]; end
            cnt = 0;
            while (!(sel8 ? ir8 : ir4)) begin
                @(negedge clk);
                cnt++;
                if (cnt > 400) begin
                    tests++; fails++;
                    $display("FAIL in_ready_timeout: waited %0d cycles, expected at most 400", cnt);
                    break;
                end
            end
            @(negedge clk);
            if (sel8) iv8 = 1'b0; else iv4 = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while ((exp4_q.size() != 0 || exp8_q.size() != 0 || bz4 || bz8) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("drain_pending", 32'(exp4_q.size() + exp8_q.size()), 0);
        check("drain_busy", {bz4, bz8}, 2'b00);
    endtask

    task automatic wait_latency(input bit sel8, output int lat);
        lat = 0;
        while (!(sel8 ? ov8 : ov4) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [7:0] pick_edge();
        case ($urandom_range(0, 3))
            0:       return 8'h80;
            1:       return 8'h7f;
            2:       return 8'h81;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        logic [15:0] x[8];
        logic [15:0] y[8];
        int          lat;
        int          xfers;
        int          cnt;

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready4", ir4, 1'b1);
        check("rst_out_valid4", ov4, 1'b0);
        check("rst_out_last4", ol4, 1'b0);
        check("rst_busy4", bz4, 1'b0);
        check("rst_out_sample4", os4, 16'h0000);
        check("rst_in_ready8", ir8, 1'b1);
        check("rst_out_valid8", ov8, 1'b0);

        // Pin the model with hand-derived values.
        x = '{default: '0};
        x[0] = 16'h0040;
        ifft_model(4, x, y);
        check("model_impulse_x0", y[0], 16'h0010);
        check("model_impulse_x3", y[3], 16'h0010);
        x[0] = 16'h0000; x[1] = 16'h0040;
        ifft_model(4, x, y);
        check("model_bin1_x1", y[1], 16'h1000);
        check("model_bin1_x2", y[2], 16'h00f0);
        check("model_bin1_x3", y[3], 16'hf000);
        ifft_model(8, x, y);
        check("model_n8_x0", y[0], 16'h0008);
        check("model_n8_x1", y[1], 16'h0505);
        check("model_n8_x2", y[2], 16'h0800);
        check("model_n8_x3", y[3], 16'h05fa);
        for (int k = 0; k < 4; k++) x[k] = 16'h007f;
        ifft_model(4, x, y);
        check("model_sat_x0", y[0], 16'h007f);
        check("model_sat_x1", y[1], 16'h0000);

        // DC impulse on N=4 with latency measurement.
        or_mode = 0;
        x = '{default: '0};
        x[0] = 16'h0040;
        send_frame(1'b0, x, 1'b0);
        wait_latency(1'b0, lat);
        check("latency_n4", lat, 3);
        wait_drain();

        x = '{default: '0};
        x[1] = 16'h0040;
        or_mode = 1;
        send_frame(1'b0, x, 1'b1);
        wait_drain();

        for (int k = 0; k < 4; k++) x[k] = 16'h007f;
        send_frame(1'b0, x, 1'b1);
        wait_drain();

        // Backpressure on the first output.
        or_mode = 2;
        x = '{default: '0};
        x[0] = 16'h0040;
        send_frame(1'b0, x, 1'b0);
        wait_latency(1'b0, lat);
        repeat (3) @(negedge clk);
        check("bp_out_sample", os4, 16'h0010);
        check("bp_out_valid", ov4, 1'b1);
        check("bp_in_ready", ir4, 1'b0);
        repeat (2) @(negedge clk);
        or_mode = 0;
        wait_drain();

        // Abort during unload after two outputs, then a clean frame.
        or_mode = 0;
        send_frame(1'b0, x, 1'b0);
        xfers = 0;
        cnt = 0;
        while (xfers < 2 && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (ov4 && ordy4) xfers++;
        end
        check("abort_reached_two", xfers, 2);
        do_reset();
        check("abort_out_valid", ov4, 1'b0);
        check("abort_in_ready", ir4, 1'b1);
        check("abort_busy", bz4, 1'b0);
        x = '{default: '0};
        x[1] = 16'h0040;
        send_frame(1'b0, x, 1'b1);
        wait_drain();

        // N=8 single bin with latency measurement.
        or_mode = 0;
        send_frame(1'b1, x, 1'b0);
        wait_latency(1'b1, lat);
        check("latency_n8", lat, 4);
        wait_drain();

        // Randomized back-to-back frames, alternating full-range and edge values.
        or_mode = 1;
        for (int r = 0; r < 14; r++) begin
            for (int k = 0; k < 8; k++)
                x[k] = (r % 2 == 0) ? 16'($urandom_range(0, 65535)) : {pick_edge(), pick_edge()};
            send_frame(1'b0, x, 1'b1);
        end
        wait_drain();
        for (int r = 0; r < 14; r++) begin
            for (int k = 0; k < 8; k++)
                x[k] = (r % 2 == 0) ? 16'($urandom_range(0, 65535)) : {pick_edge(), pick_edge()};
            send_frame(1'b1, x, 1'b1);
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
